// File: rtl/cmos_frame_capture.sv
// DVP camera capture: registers VSYNC/HREF/data, assembles RGB565 (or RGB888 when
// CMOS_RGB888_EN is defined) byte groups into 24-bit pixels with SOP/EOP markers.
module cmos_frame_capture #(
  parameter int unsigned H_PIXELS    = 640,
  parameter int unsigned V_LINES     = 720,
  parameter int unsigned WAIT_FRAMES = 10
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_herf,
  input  logic [7:0]  cmos_data,
  input  logic        cmos_cfg_done,
  output logic        cmos_frame_valid_w,
  output logic [23:0] cmos_frame_data,
  output logic        cmos_frame_sop_w,
  output logic        cmos_frame_eop_w
);

  localparam logic [31:0] TOTAL_PIX = 32'(H_PIXELS * V_LINES);
  localparam int unsigned WW = (WAIT_FRAMES > 0) ? $clog2(WAIT_FRAMES + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_FRAMES);
`ifdef CMOS_RGB888_EN
  localparam logic [1:0] LAST_PHASE = 2'd2;
`else
  localparam logic [1:0] LAST_PHASE = 2'd1;
`endif

  logic          r_vsync, r_vsync_d, r_herf;
  logic [7:0]    r_data, r_b0;
`ifdef CMOS_RGB888_EN
  logic [7:0]    r_b1;
`endif
  logic [1:0]    r_phase;
  logic [WW-1:0] r_wait_cnt;
  logic          r_out_en;
  logic [31:0]   r_pix_cnt;
  logic          r_sop_arm;
  logic          r_done;

  logic          w_frame_start;
  logic          w_pix;
  logic          w_emit;
  logic [31:0]   w_cnt_next;
  logic          w_last_pix;
  logic [23:0]   w_pixel;

  always_comb begin
    w_frame_start = r_vsync & ~r_vsync_d;
    w_pix         = r_herf && (r_phase == LAST_PHASE);
    // cfg_done gates directly so a drop suppresses the pixel registered on that same edge
    w_emit        = w_pix && r_out_en && cmos_cfg_done && !r_done;
    w_cnt_next    = r_pix_cnt + 32'd1;
    w_last_pix    = (w_cnt_next == TOTAL_PIX);
`ifdef CMOS_RGB888_EN
    w_pixel       = {r_b0, r_b1, r_data};
`else
    w_pixel       = {r_b0[7:3], r_b0[7:5],
                     r_b0[2:0], r_data[7:5], r_b0[2:1],
                     r_data[4:0], r_data[4:2]};
`endif
  end

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      r_vsync            <= 1'b0;
      r_vsync_d          <= 1'b0;
      r_herf             <= 1'b0;
      r_data             <= '0;
      r_b0               <= '0;
`ifdef CMOS_RGB888_EN
      r_b1               <= '0;
`endif
      r_phase            <= '0;
      r_wait_cnt         <= '0;
      r_out_en           <= 1'b0;
      r_pix_cnt          <= '0;
      r_sop_arm          <= 1'b0;
      r_done             <= 1'b0;
      cmos_frame_valid_w <= 1'b0;
      cmos_frame_data    <= '0;
      cmos_frame_sop_w   <= 1'b0;
      cmos_frame_eop_w   <= 1'b0;
    end else begin
      r_vsync   <= cmos_vsync;
      r_vsync_d <= r_vsync;
      r_herf    <= cmos_herf;
      r_data    <= cmos_data;

      // Enable is decided from the pre-increment count, so frame WAIT_FRAMES+1 is the first shown
      if (!cmos_cfg_done) begin
        r_wait_cnt <= '0;
        r_out_en   <= 1'b0;
      end else if (w_frame_start) begin
        r_out_en <= (r_wait_cnt == WAIT_MAX);
        if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (!r_herf || r_phase == LAST_PHASE) r_phase <= '0;
      else                                  r_phase <= r_phase + 2'd1;
      if (r_herf && r_phase == 2'd0) r_b0 <= r_data;
`ifdef CMOS_RGB888_EN
      if (r_herf && r_phase == 2'd1) r_b1 <= r_data;
`endif

      cmos_frame_valid_w <= w_emit;
      cmos_frame_sop_w   <= w_emit && r_sop_arm;
      cmos_frame_eop_w   <= w_emit && w_last_pix;
      if (w_emit) cmos_frame_data <= w_pixel;

      // A pixel emitted on the frame-start edge still belongs to the old frame
      if (w_frame_start) begin
        r_pix_cnt <= '0;
        r_sop_arm <= 1'b1;
        r_done    <= 1'b0;
      end else if (w_emit) begin
        r_pix_cnt <= w_cnt_next;
        r_sop_arm <= 1'b0;
        if (w_last_pix) r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Directed bench for cmos_frame_capture in RGB565 mode (4x2 frame, WAIT_FRAMES=2).
module tb_cmos_frame_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        herf = 1'b0;
  logic [7:0]  data = '0;
  logic        cfg_done = 1'b0;
  logic        valid;
  logic [23:0] pdata;
  logic        sop;
  logic        eop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [23:0] q_data[$];
  logic        q_sop[$];
  logic        q_eop[$];
  int          q_cyc[$];
  int          n_sop_hi = 0;
  int          n_eop_hi = 0;
  int          n_b2b = 0;
  logic        prev_valid = 1'b0;

  logic [7:0]  lb[16];
  int          lcyc[16];

  localparam logic [23:0] EXP_STD[4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000};

  cmos_frame_capture #(
    .H_PIXELS(4),
    .V_LINES(2),
    .WAIT_FRAMES(2)
  ) dut (
    .cmos_pclk(clk),
    .rst_n(rst_n),
    .cmos_vsync(vsync),
    .cmos_herf(herf),
    .cmos_data(data),
    .cmos_cfg_done(cfg_done),
    .cmos_frame_valid_w(valid),
    .cmos_frame_data(pdata),
    .cmos_frame_sop_w(sop),
    .cmos_frame_eop_w(eop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      q_data.push_back(pdata);
      q_sop.push_back(sop);
      q_eop.push_back(eop);
      q_cyc.push_back(cyc);
    end
    if (sop) n_sop_hi++;
    if (eop) n_eop_hi++;
    if (valid && prev_valid) n_b2b++;
    prev_valid = valid;
  end

  task automatic clear_mon();
    @(posedge clk);
    q_data.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete();
    n_sop_hi = 0; n_eop_hi = 0; n_b2b = 0;
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    vsync = v; herf = h; data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_start_pulse();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    idle(3);
  endtask

  task automatic put(input logic [7:0] a, b, c, d, e, f, g, h);
    lb[0] = a; lb[1] = b; lb[2] = c; lb[3] = d;
    lb[4] = e; lb[5] = f; lb[6] = g; lb[7] = h;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, lb[i]);
      lcyc[i] = cyc;
    end
    idle(4);
  endtask

  task automatic send_full_frame();
    frame_start_pulse();
    put(8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hF8, 8'h00);
    send_line(8);
    send_line(8);
  endtask

  task automatic check_full_frame(input string tag);
    checks++;
    if (q_data.size() !== 8) begin
      failures++;
      $display("FAIL %s_count: got %0d valids, expected 8", tag, q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_data[k] !== EXP_STD[k % 4] || q_sop[k] !== (k == 0) || q_eop[k] !== (k == 7)) begin
          failures++;
          $display("FAIL %s_pix%0d: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b",
                   tag, k, q_data[k], q_sop[k], q_eop[k], EXP_STD[k % 4], k == 0, k == 7);
        end
      end
    end
    checks++;
    if (n_sop_hi !== 1 || n_eop_hi !== 1 || n_b2b !== 0) begin
      failures++;
      $display("FAIL %s_widths: sop_cycles=%0d eop_cycles=%0d back_to_back=%0d, expected 1 1 0",
               tag, n_sop_hi, n_eop_hi, n_b2b);
    end
  endtask

  task automatic check_no_valid(input string tag);
    checks++;
    if (q_data.size() !== 0) begin
      failures++;
      $display("FAIL %s: got %0d valids, expected 0", tag, q_data.size());
    end
  endtask

  task automatic test_reset();
    cfg_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({valid, pdata, sop, eop} !== 27'd0) begin
        failures++;
        $display("FAIL reset_cyc%0d: got valid=%b data=%h sop=%b eop=%b, expected all 0",
                 i, valid, pdata, sop, eop);
      end
      vsync = 1'($urandom); herf = 1'($urandom); data = 8'($urandom);
    end
    @(negedge clk);
    vsync = 1'b0; herf = 1'b0; data = 8'h00; rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_frame_wait();
    clear_mon();
    send_full_frame();
    check_no_valid("wait_frame1");
    send_full_frame();
    check_no_valid("wait_frame2");
    clear_mon();
    send_full_frame();
    check_full_frame("wait_frame3");
  endtask

  task automatic test_conversion();
    logic [23:0] exp_px[3];
    exp_px[0] = 24'hFF0000; exp_px[1] = 24'h00FF00; exp_px[2] = 24'h0000FF;
    clear_mon();
    frame_start_pulse();
    put(8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h00, 8'h00);
    send_line(6);
    checks++;
    if (q_data.size() !== 3) begin
      failures++;
      $display("FAIL conv_count: got %0d valids, expected 3", q_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q_data[k] !== exp_px[k] || q_cyc[k] !== lcyc[2*k+1] + 2) begin
          failures++;
          $display("FAIL conv_pix%0d: got data=%h at cyc %0d, expected data=%h at cyc %0d",
                   k, q_data[k], q_cyc[k], exp_px[k], lcyc[2*k+1] + 2);
        end
      end
      checks++;
      if (q_sop[0] !== 1'b1 || n_eop_hi !== 0) begin
        failures++;
        $display("FAIL conv_markers: got sop0=%b eop_cycles=%0d, expected 1 0", q_sop[0], n_eop_hi);
      end
    end
  endtask

  task automatic test_markers();
    clear_mon();
    send_full_frame();
    check_full_frame("markers");
    clear_mon();
    send_line(8);
    check_no_valid("after_eop_line");
  endtask

  task automatic test_boundaries();
    logic [23:0] exp_px[6];
    exp_px[0] = 24'hFF0000; exp_px[1] = 24'h00FF00; exp_px[2] = 24'h0000FF;
    exp_px[3] = 24'hFF0000; exp_px[4] = 24'h00FF00; exp_px[5] = 24'h0000FF;
    clear_mon();
    frame_start_pulse();
    put(8'hF8, 8'h00, 8'h07, 8'hE0, 8'hAA, 8'h00, 8'h00, 8'h00);
    send_line(5);
    put(8'h00, 8'h1F, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F);
    send_line(8);
    checks++;
    if (q_data.size() !== 6) begin
      failures++;
      $display("FAIL odd_count: got %0d valids, expected 6", q_data.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (q_data[k] !== exp_px[k]) begin
          failures++;
          $display("FAIL odd_pix%0d: got %h, expected %h", k, q_data[k], exp_px[k]);
        end
      end
    end
    checks++;
    if (n_eop_hi !== 0) begin
      failures++;
      $display("FAIL short_frame_eop: got %0d eop cycles, expected 0", n_eop_hi);
    end
    clear_mon();
    send_full_frame();
    check_full_frame("after_short");
  endtask

  task automatic test_cfg_drop();
    int drop_cyc;
    clear_mon();
    frame_start_pulse();
    put(8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hF8, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, lb[i]);
    @(negedge clk);
    cfg_done = 1'b0; vsync = 1'b0; herf = 1'b1; data = lb[4];
    drop_cyc = cyc;
    for (int i = 5; i < 8; i++) drive(1'b0, 1'b1, lb[i]);
    idle(4);
    checks++;
    if (q_data.size() !== 1) begin
      failures++;
      $display("FAIL cfg_drop_count: got %0d valids, expected 1", q_data.size());
    end else begin
      checks++;
      if (q_cyc[0] !== drop_cyc - 1 || q_data[0] !== 24'hFF0000) begin
        failures++;
        $display("FAIL cfg_drop_pix: got %h at cyc %0d, expected ff0000 at cyc %0d",
                 q_data[0], q_cyc[0], drop_cyc - 1);
      end
    end
    @(negedge clk);
    cfg_done = 1'b1;
    clear_mon();
    send_full_frame();
    check_no_valid("rewait_frame1");
    send_full_frame();
    check_no_valid("rewait_frame2");
    clear_mon();
    send_full_frame();
    check_full_frame("rewait_frame3");
  endtask

  initial begin
    test_reset();
    test_frame_wait();
    test_conversion();
    test_markers();
    test_boundaries();
    test_cfg_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
